pipe_out_fifo: RTL and testbench
================================

# pipe_out_fifo

Buffered host-read ("pipe out") endpoint: user logic pushes 32-bit words into an internal FIFO, and the host drains them through ti_read strobes addressed to this endpoint. It is the transmit-to-host counterpart of the pipe-in endpoint. It sits on the host interface bus beside the other endpoints, with its data output zero whenever it is not being read, so outputs can be OR-combined.

## Interface
Parameters:
- DEPTH_LOG2, 10: FIFO depth is 2**DEPTH_LOG2 words.
- BLOCK_WORDS, 256: minimum occupancy for ti_ready to assert. Must satisfy 1 ≤ BLOCK_WORDS ≤ 2**DEPTH_LOG2.

Ports:
- ti_clk, in, 1: the only clock.
- ti_reset, in, 1: synchronous, active-high reset.
- ti_addr, in, 8: endpoint address currently on the host bus.
- ti_read, in, 1: host read strobe.
- ep_addr, in, 8: this endpoint's address, static.
- ti_dataout, out, 32: read data to the host. Zero except in the cycle after a read hit.
- ti_ready, out, 1: combinational. Equals (ti_addr == ep_addr) && (count ≥ BLOCK_WORDS).
- ep_read, out, 1: registered one-cycle pulse for each read hit, including underflow reads.
- wr_en, in, 1: user push request.
- wr_data, in, 32: user push data.
- full, out, 1: combinational. Equals (count == 2**DEPTH_LOG2).
- count, out, DEPTH_LOG2+1: current occupancy, registered.
- overflow, out, 1: sticky. Set when a push is dropped.
- underflow, out, 1: sticky. Set when a read hit finds the FIFO empty.

## Operation
- Read hit: ti_read && (ti_addr == ep_addr), sampled at the rising edge of ti_clk.
- Storage: circular buffer of 2**DEPTH_LOG2 words, with DEPTH_LOG2-bit wr_ptr and rd_ptr. Both pointers wrap modulo depth. count is tracked separately, so full and empty are unambiguous.
- Push accepted when wr_en && (count < depth, or a read hit on a non-empty FIFO happens in the same edge):
  - mem[wr_ptr] ← wr_data; wr_ptr++.
- Push when full with no concurrent pop: word dropped, pointers unchanged, overflow ← 1.
- Read hit with count > 0:
  - ti_dataout ← mem[rd_ptr]; rd_ptr++; ep_read ← 1.
- Read hit with count == 0:
  - ti_dataout ← 0; ep_read ← 1; underflow ← 1.
  - No fall-through: a word pushed in the same edge is stored, but it is not returned by this read.
- Any edge without a read hit: ti_dataout ← 0, ep_read ← 0.
- count update per edge: +1 for an accepted push, −1 for a successful pop. A push and pop in the same edge leave count unchanged.
- Read order is strictly FIFO. No word is duplicated or skipped across pointer wrap.
- overflow and underflow are cleared only by ti_reset.

## Timing
- Reset (edge with ti_reset = 1):
  - wr_ptr, rd_ptr, and count ← 0.
  - ti_dataout ← 0; ep_read ← 0; overflow ← 0; underflow ← 0.
  - Memory contents are don't-care.
  - Reset overrides a concurrent push or read hit; both are ignored.
  - Reset mid-burst discards all buffered words.
- Read latency: a read hit sampled at edge k gives ti_dataout and ep_read valid from edge k through edge k+1, a window of exactly one cycle. The host samples data one cycle after its strobe.
- Back-to-back read hits on consecutive edges return consecutive words, one per cycle.
- Push-to-readable latency: a word pushed at edge k counts toward count from edge k. It can be read by a read hit at edge k+1 or later.
- ti_ready reflects the registered count combinationally. It follows changes to ti_addr in the same cycle.
- full reflects count combinationally and deasserts in the cycle after the pop edge.
- Throughput: one push and one pop per cycle, sustained, at any occupancy.

## Test plan
- Reset, then push 0x00000001..0x00000004 on 4 consecutive cycles, then 4 consecutive read hits with ep_addr = 0xA0:
  - Read data 1, 2, 3, 4 each one cycle after its strobe.
  - ep_read pulses 4 times; count ends at 0; ti_dataout is 0 otherwise.
- Read hit on an empty FIFO: ti_dataout = 0, ep_read = 1, underflow = 1 (sticky). A read with ti_addr = 0xA1 (mismatch) causes no ep_read and no pointer change.
- Fill to full (depth words), push 0xDEADBEEF:
  - overflow = 1 and count stays at depth.
  - Draining returns the original words only; 0xDEADBEEF is never seen.
- At full, push and read hit in the same edge: push accepted, count stays at depth, and FIFO order is preserved.
- Wrap: with DEPTH_LOG2 = 2, run 10 interleaved push/read cycles with an incrementing pattern. The output sequence is exactly the input sequence. ti_ready with BLOCK_WORDS = 2 asserts only when count ≥ 2 and ti_addr = ep_addr.
- With 3 words buffered, assert ti_reset for one cycle during a read burst: count = 0, all outputs 0, and the next read hit underflows.

Source files
------------

// File: rtl/pipe_out_fifo.sv
// Host-read pipe endpoint: user logic pushes 32-bit words into a circular buffer,
// and host read strobes addressed to this endpoint drain it one word per cycle.
module pipe_out_fifo #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  ti_clk,
  input  logic                  ti_reset,
  input  logic [7:0]            ti_addr,
  input  logic                  ti_read,
  input  logic [7:0]            ep_addr,
  output logic [31:0]           ti_dataout,
  output logic                  ti_ready,
  output logic                  ep_read,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] BLOCK_CNT = (DEPTH_LOG2+1)'(BLOCK_WORDS);

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [31:0]           dout_q, dout_d;
  logic                  ep_read_q, ep_read_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic read_hit, empty, pop, push;

  always_comb begin
    read_hit = ti_read && (ti_addr == ep_addr);
    empty    = (count_q == '0);
    pop      = read_hit && !empty;
    // A pop on the same edge frees a slot, so a full FIFO still takes the push.
    push     = wr_en && ((count_q != DEPTH_CNT) || pop);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dout_d    = '0;
    ep_read_d = read_hit;
    ovf_d     = ovf_q;
    unf_d     = unf_q;

    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop) begin
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase

    if (wr_en && !push)   ovf_d = 1'b1;
    if (read_hit && empty) unf_d = 1'b1;
  end

  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dout_q    <= '0;
      ep_read_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      ep_read_q <= ep_read_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Storage has no reset; contents are only meaningful between the pointers.
  always_ff @(posedge ti_clk) begin
    if (!ti_reset && push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign ti_dataout = dout_q;
  assign ep_read    = ep_read_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign full       = (count_q == DEPTH_CNT);
  assign ti_ready   = (ti_addr == ep_addr) && (count_q >= BLOCK_CNT);

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Bench for pipe_out_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_out_fifo;
  localparam int DL   = 2;
  localparam int BW   = 2;
  localparam int DEP  = 1 << DL;
  localparam logic [7:0] EP = 8'hA0;

  logic        ti_clk = 1'b0;
  logic        ti_reset = 1'b1;
  logic [7:0]  ti_addr = 8'h00;
  logic        ti_read = 1'b0;
  logic [7:0]  ep_addr = EP;
  logic [31:0] ti_dataout;
  logic        ti_ready, ep_read, wr_en = 1'b0, full, overflow, underflow;
  logic [31:0] wr_data = '0;
  logic [DL:0] count;

  pipe_out_fifo #(.DEPTH_LOG2(DL), .BLOCK_WORDS(BW)) dut (
    .ti_clk(ti_clk), .ti_reset(ti_reset), .ti_addr(ti_addr), .ti_read(ti_read),
    .ep_addr(ep_addr), .ti_dataout(ti_dataout), .ti_ready(ti_ready),
    .ep_read(ep_read), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow));

  always #5 ti_clk = ~ti_clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus the registered read-side outputs.
  logic [31:0] mq[$];
  logic [31:0] m_dout = '0;
  bit          m_ep = 0, m_ov = 0, m_un = 0;

  always @(posedge ti_clk) begin
    if (ti_reset) begin
      mq.delete();
      m_dout = '0; m_ep = 0; m_ov = 0; m_un = 0;
    end else begin
      automatic bit hit = ti_read && (ti_addr == ep_addr);
      automatic int had = mq.size();
      automatic bit did_pop = hit && (had > 0);
      m_ep   = hit;
      m_dout = did_pop ? mq.pop_front() : 32'h0;
      if (hit && had == 0) m_un = 1;
      if (wr_en) begin
        if (had < DEP || did_pop) mq.push_back(wr_data);
        else m_ov = 1;
      end
    end
  end

  always @(negedge ti_clk) begin
    if (chk_en) begin
      chk("count",     32'(count),     32'(mq.size()));
      chk("dataout",   ti_dataout,     m_dout);
      chk("ep_read",   32'(ep_read),   32'(m_ep));
      chk("overflow",  32'(overflow),  32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_un));
      chk("full",      32'(full),      32'(mq.size() == DEP));
      chk("ti_ready",  32'(ti_ready),  32'((ti_addr == ep_addr) && (mq.size() >= BW)));
    end
  end

  task automatic tick(input logic w, input logic [31:0] d, input logic r,
                      input logic [7:0] a, input logic rst);
    wr_en = w; wr_data = d; ti_read = r; ti_addr = a; ti_reset = rst;
    @(posedge ti_clk);
    #2;
  endtask

  initial begin
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {30'd0, overflow, underflow}, 0);

    // Push 1..4 then read them back in order.
    for (int i = 1; i <= 4; i++) tick(1, i, 0, EP, 0);
    chk("filled_full", 32'(full), 1);
    for (int i = 1; i <= 4; i++) begin
      tick(0, 0, 1, EP, 0);
      chk("seq_data", ti_dataout, i);
      chk("seq_ep", 32'(ep_read), 1);
    end
    tick(0, 0, 0, EP, 0);
    chk("seq_idle_data", ti_dataout, 0);
    chk("seq_count0", 32'(count), 0);

    // Underflow, then address mismatch.
    tick(0, 0, 1, EP, 0);
    chk("unf_data", ti_dataout, 0);
    chk("unf_ep", 32'(ep_read), 1);
    chk("unf_flag", 32'(underflow), 1);
    tick(1, 32'h77, 0, EP, 0);
    tick(0, 0, 1, 8'hA1, 0);
    chk("miss_ep", 32'(ep_read), 0);
    chk("miss_count", 32'(count), 1);
    tick(0, 0, 1, EP, 0);
    chk("miss_data", ti_dataout, 32'h77);

    // Fill, overflow, push+pop at full, drain.
    for (int i = 0; i < DEP; i++) tick(1, 32'h10 + i, 0, EP, 0);
    tick(1, 32'hDEADBEEF, 0, EP, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), DEP);
    tick(1, 32'h55, 1, EP, 0);
    chk("full_pp_data", ti_dataout, 32'h10);
    chk("full_pp_count", 32'(count), DEP);
    for (int i = 1; i < DEP; i++) begin
      tick(0, 0, 1, EP, 0);
      chk("drain_data", ti_dataout, 32'h10 + i);
    end
    tick(0, 0, 1, EP, 0);
    chk("drain_last", ti_dataout, 32'h55);

    // Wrap with interleaved push/read.
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1, 32'h100 + i, i > 0, (i % 3 == 2) ? 8'hA1 : EP, 0);
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 1, EP, 0);

    // Reset during a read burst.
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1, 32'h200 + i, 0, EP, 0);
    tick(0, 0, 1, EP, 0);
    chk("burst_data", ti_dataout, 32'h200);
    tick(0, 0, 1, EP, 1);
    chk("rstb_count", 32'(count), 0);
    chk("rstb_out", {ti_dataout[29:0], ep_read, underflow}, 0);
    tick(0, 0, 1, EP, 0);
    chk("rstb_unf", 32'(underflow), 1);
    chk("rstb_data", ti_dataout, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0 ? 8'hA1 : EP, $urandom_range(0, 63) == 0);
    end
    tick(0, 0, 0, EP, 0);
    @(negedge ti_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
